// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator and amplitude scaler that feeds the PWM sample bus.
// Define ADSR_EXP_RELEASE_EN to get an exponential-like release tail instead of a linear one.
`timescale 1ns/1ps

module adsr_envelope #(
    parameter int ACC_W = 16  // must be at least 9
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       strobe,
    input  logic       note_on,
    input  logic [7:0] wave_in,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_rate,
    output logic [7:0] sample_o,
    output logic [7:0] env_o,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_gate_q;
    logic             r_busy;
    logic [7:0]       r_sample;

    logic             w_rise;
    logic             w_fall;
    logic [7:0]       w_env;
    logic [ACC_W-1:0] w_target;
    logic [ACC_W-1:0] w_rel_step;
    logic [ACC_W:0]   w_att_sum;
    logic [ACC_W:0]   w_dec_diff;
    logic [ACC_W:0]   w_rel_diff;
    logic             w_att_done;
    logic             w_dec_done;
    logic             w_rel_done;

    logic signed [8:0]  w_wave_s;
    logic signed [17:0] w_prod;
    logic [7:0]         w_scaled;
    logic               w_unused;

    assign w_rise   = note_on & ~r_gate_q;
    assign w_fall   = ~note_on & r_gate_q;
    assign w_env    = r_acc[ACC_W-1 -: 8];
    assign w_target = ACC_W'(sustain_level) << (ACC_W - 8);

`ifdef ADSR_EXP_RELEASE_EN
    assign w_rel_step = (r_acc >> 4) + ACC_W'(release_rate);
`else
    assign w_rel_step = ACC_W'(release_rate);
`endif

    // One extra bit on every step so overflow and underflow show up as bit ACC_W.
    assign w_att_sum  = {1'b0, r_acc} + (ACC_W+1)'(attack_rate);
    assign w_dec_diff = {1'b0, r_acc} - (ACC_W+1)'(decay_rate);
    assign w_rel_diff = {1'b0, r_acc} - {1'b0, w_rel_step};

    assign w_att_done = (w_att_sum >= {1'b0, ACC_MAX}) || (attack_rate == 8'd0);
    assign w_dec_done = w_dec_diff[ACC_W] || (w_dec_diff[ACC_W-1:0] <= w_target)
                        || (decay_rate == 8'd0);
    assign w_rel_done = w_rel_diff[ACC_W] || (w_rel_diff[ACC_W-1:0] == '0)
                        || (release_rate == 8'd0);

    // Centred sample times envelope; bits [15:8] of the product are the floor-shifted
    // value modulo 256, and adding midscale back can never leave 0..254.
    assign w_wave_s = $signed({1'b0, wave_in}) - 9'sd128;
    assign w_prod   = w_wave_s * $signed({1'b0, w_env});
    assign w_scaled = w_prod[15:8] + 8'd128;
    assign w_unused = ^{w_prod[17:16], w_prod[7:0]};

    // NOTE: state updates use non-blocking assignments so every branch sees pre-edge values;
    // all registers here are plain flops, so each one gets an async reset value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_gate_q <= 1'b0;
            r_busy   <= 1'b0;
            r_sample <= 8'd128;
        end else begin
            r_gate_q <= note_on;

            if (strobe) begin
                r_sample <= w_scaled;
            end

            if (w_rise) begin
                r_state <= ST_ATTACK;
                r_busy  <= 1'b1;
            end else if (w_fall) begin
                if (r_state == ST_ATTACK || r_state == ST_DECAY || r_state == ST_SUSTAIN) begin
                    r_state <= ST_RELEASE;
                end
            end else if (strobe) begin
                case (r_state)
                    ST_ATTACK: begin
                        if (w_att_done) begin
                            r_acc   <= ACC_MAX;
                            r_state <= ST_DECAY;
                        end else begin
                            r_acc <= w_att_sum[ACC_W-1:0];
                        end
                    end
                    ST_DECAY: begin
                        if (w_dec_done) begin
                            r_acc   <= w_target;
                            r_state <= ST_SUSTAIN;
                        end else begin
                            r_acc <= w_dec_diff[ACC_W-1:0];
                        end
                    end
                    ST_SUSTAIN: begin
                        r_acc <= w_target;
                    end
                    ST_RELEASE: begin
                        if (w_rel_done) begin
                            r_acc   <= '0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_acc <= w_rel_diff[ACC_W-1:0];
                        end
                    end
                    default: begin
                        r_acc <= '0;
                    end
                endcase
            end
        end
    end

    assign sample_o = r_sample;
    assign env_o    = w_env;
    assign busy     = r_busy;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed self-checking bench for adsr_envelope: scaling tables plus hand-written
// sequences for attack/decay/sustain timing, release, retrigger and async reset.
`timescale 1ns/1ps

module tb_adsr_envelope;

    logic       clk;
    logic       n_rst;
    logic       strobe;
    logic       note_on;
    logic [7:0] wave_in;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] sustain_level;
    logic [7:0] release_rate;
    logic [7:0] sample_o;
    logic [7:0] env_o;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] wave;
        logic [7:0] exp_ff;  // expected sample_o with env_o = 0xFF
        logic [7:0] exp_80;  // expected sample_o with env_o = 0x80
    } scale_vec_t;

    scale_vec_t vecs [7];

    adsr_envelope #(.ACC_W(16)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .strobe       (strobe),
        .note_on      (note_on),
        .wave_in      (wave_in),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .sample_o     (sample_o),
        .env_o        (env_o),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given strobe value; returns 1 ns after the edge.
    task automatic cycle(input logic s);
        strobe = s;
        @(posedge clk);
        #1;
        strobe = 1'b0;
    endtask

    task automatic strb4();
        cycle(1'b1);
        repeat (3) cycle(1'b0);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 8'h40};
        vecs[1] = '{8'hFF, 8'hFE, 8'hBF};
        vecs[2] = '{8'h80, 8'h80, 8'h80};
        vecs[3] = '{8'hC0, 8'hBF, 8'hA0};
        vecs[4] = '{8'h7F, 8'h7F, 8'h7F};
        vecs[5] = '{8'h81, 8'h80, 8'h80};
        vecs[6] = '{8'h40, 8'h40, 8'h60};

        n_rst         = 1'b0;
        strobe        = 1'b0;
        note_on       = 1'b0;
        wave_in       = 8'h80;
        attack_rate   = 8'h00;
        decay_rate    = 8'h00;
        sustain_level = 8'h00;
        release_rate  = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset sample_o", 16'(sample_o), 16'h80);
        check("reset env_o", 16'(env_o), 16'h00);
        check("reset busy", 16'(busy), 16'h0);

        n_rst = 1'b1;
        repeat (3) cycle(1'b1);
        check("idle busy", 16'(busy), 16'h0);
        check("idle env_o", 16'(env_o), 16'h00);

        // Linear attack then decay into sustain, one strobe every 4 clocks.
        attack_rate   = 8'h80;
        decay_rate    = 8'h40;
        sustain_level = 8'h80;
        release_rate  = 8'h00;
        note_on       = 1'b1;
        cycle(1'b0);
        check("attack start busy", 16'(busy), 16'h1);
        check("attack start env_o", 16'(env_o), 16'h00);
        repeat (509) strb4();
        check("attack 509 env_o", 16'(env_o), 16'hFE);
        repeat (2) strb4();
        check("attack 511 env_o", 16'(env_o), 16'hFF);
        strb4();
        check("attack 512 env_o", 16'(env_o), 16'hFF);
        check("attack 512 busy", 16'(busy), 16'h1);
        repeat (256) strb4();
        check("decay 256 env_o", 16'(env_o), 16'hBF);
        repeat (256) strb4();
        check("decay 512 env_o", 16'(env_o), 16'h80);

        sustain_level = 8'h60;
        cycle(1'b1);
        check("sustain tracks env_o", 16'(env_o), 16'h60);
        sustain_level = 8'h80;
        cycle(1'b1);
        check("sustain back env_o", 16'(env_o), 16'h80);

        foreach (vecs[i]) begin
            wave_in = vecs[i].wave;
            cycle(1'b1);
            check($sformatf("scale80 wave=%0h", vecs[i].wave), 16'(sample_o), 16'(vecs[i].exp_80));
        end
        wave_in = 8'h00;
        repeat (2) cycle(1'b0);
        check("sample holds without strobe", 16'(sample_o), 16'(vecs[6].exp_80));

        // Instantaneous release.
        release_rate = 8'h00;
        note_on      = 1'b0;
        cycle(1'b0);
        check("release entry busy", 16'(busy), 16'h1);
        check("release entry env_o", 16'(env_o), 16'h80);
        wave_in = 8'hFF;
        cycle(1'b1);
        check("release instant env_o", 16'(env_o), 16'h00);
        check("release instant busy", 16'(busy), 16'h0);
        check("release old env sample", 16'(sample_o), 16'hBF);
        cycle(1'b1);
        check("idle sample_o", 16'(sample_o), 16'h80);

        // Full-scale envelope for the scaling table.
        attack_rate   = 8'h00;
        decay_rate    = 8'h01;
        sustain_level = 8'h10;
        note_on       = 1'b1;
        cycle(1'b0);
        check("retrigger busy", 16'(busy), 16'h1);
        wave_in = 8'h80;
        cycle(1'b1);
        check("instant attack env_o", 16'(env_o), 16'hFF);
        foreach (vecs[i]) begin
            wave_in = vecs[i].wave;
            cycle(1'b1);
            check($sformatf("scaleFF wave=%0h", vecs[i].wave), 16'(sample_o), 16'(vecs[i].exp_ff));
        end

        // Retrigger colliding with a strobe while releasing.
        decay_rate    = 8'h00;
        sustain_level = 8'h41;
        cycle(1'b1);
        check("instant decay env_o", 16'(env_o), 16'h41);
        release_rate = 8'hC0;
        note_on      = 1'b0;
        cycle(1'b0);
        check("release2 entry busy", 16'(busy), 16'h1);
        cycle(1'b1);
        check("linear release env_o", 16'(env_o), 16'h40);
        attack_rate = 8'hF0;
        note_on     = 1'b1;
        cycle(1'b1);
        check("collision env_o", 16'(env_o), 16'h40);
        check("collision busy", 16'(busy), 16'h1);
        cycle(1'b1);
        check("retrigger attack env_o", 16'(env_o), 16'h41);
        cycle(1'b1);
        check("attack continues env_o", 16'(env_o), 16'h42);

        // Asynchronous reset mid-attack.
        #2;
        n_rst = 1'b0;
        #1;
        check("async reset sample_o", 16'(sample_o), 16'h80);
        check("async reset env_o", 16'(env_o), 16'h00);
        check("async reset busy", 16'(busy), 16'h0);
        note_on = 1'b0;
        cycle(1'b0);
        n_rst = 1'b1;
        repeat (3) cycle(1'b1);
        check("post reset busy", 16'(busy), 16'h0);
        check("post reset env_o", 16'(env_o), 16'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
